// File: rtl/async_pkg.sv
// Shared types and constants for the asynchronous-boundary library.
package async_pkg;

    // Handshake state of a 4-phase bundled-data receiver.
    typedef enum logic {
        IDLE,
        ACKED
    } bd4_state_t;

    // Legal depth range of a request synchroniser.
    localparam int unsigned BD4_SYNC_MIN = 2;
    localparam int unsigned BD4_SYNC_MAX = 4;

endpackage

// File: rtl/sync_ff.sv
// 1-bit flop-chain synchroniser; asynchronous active-low reset to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the chain; only the last flop is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/bd4_sync_sink.sv
// Clocked receiver for a 4-phase bundled-data channel: synchronises the
// request, captures the bundled word into a one-entry valid/ready buffer and
// returns the acknowledge.
module bd4_sync_sink
    import async_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (SYNC_STAGES < BD4_SYNC_MIN || SYNC_STAGES > BD4_SYNC_MAX) begin : g_bad_sync
        $error("bd4_sync_sink: SYNC_STAGES must be in 2..4");
    end

    logic             req_s;
    logic             can_load;
    logic             load;
    bd4_state_t       state_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (req_in),
        .q_o   (req_s)
    );

    // Buffer is empty, or its word leaves on this edge.
    assign can_load = !valid_q || out_ready;
    // data_in is only trusted once the synchronised request is seen in IDLE.
    assign load     = (state_q == IDLE) && req_s && can_load;

    // Handshake FSM plus the one-entry output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE:  if (load) state_q <= ACKED;
                ACKED: if (!req_s) state_q <= IDLE;
            endcase

            if (load) begin
                data_q  <= data_in;
                valid_q <= 1'b1;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Acknowledge depends on the state flop only, never on req_s directly.
    assign ack_out   = (state_q == ACKED);
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: doc/bd4_sync_sink.md
# bd4_sync_sink

Clocked receiver for a 4-phase, bundled-data asynchronous channel. The asynchronous sender drives `req_in` after its matched delay element, with `data_in` held stable. This block synchronises `req_in`, captures the bundled word into a one-entry output register, and returns `ack_out`. It presents the word to synchronous logic over a valid/ready interface. It sits at the boundary where the self-timed pipelines in the async library feed clocked logic.

## Interface
- `WIDTH`, 8, width of the bundled data word.
- `SYNC_STAGES`, 2, number of flip-flops in the `req_in` synchroniser; legal range 2..4.

Ports:
- `clk`  in  1  single clock for all sequential logic.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_in`  in  1  asynchronous 4-phase request from the sender; synchronised internally.
- `data_in`  in  WIDTH  bundled data; stable from before `req_in` rises until `ack_out` rises.
- `ack_out`  out  1  4-phase acknowledge to the sender; driven directly from a flip-flop.
- `out_valid`  out  1  output register holds an unconsumed word.
- `out_ready`  in  1  downstream accepts the word when `out_valid && out_ready` at a rising edge.
- `out_data`  out  WIDTH  captured word.

## Operation
- Reset values: `ack_out`=0, `out_valid`=0, `out_data`=0, FSM=IDLE, synchroniser flops=0.
- `req_s` is the output of the SYNC_STAGES-deep synchroniser on `req_in`. `data_in` is never synchronised; it is only sampled when `req_s`=1, as the bundling constraint guarantees.
- `can_load` = `!out_valid || out_ready`, meaning the buffer is empty or drains on this edge.
- IDLE (`ack_out`=0):
  - If `req_s`=1 and `can_load`: load `out_data` from `data_in`, set `out_valid`=1 and `ack_out`=1, and go to ACKED.
  - If `req_s`=1 and `!can_load`: stay in IDLE. This is backpressure; the sender stalls with `req_in` high.
- ACKED (`ack_out`=1):
  - If `req_s`=0: set `ack_out`=0 and go to IDLE.
  - Otherwise stay in ACKED.
  - No capture is allowed in ACKED.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` unless a load happens on the same edge.
  - A simultaneous load and drain leaves `out_valid`=1 and holds the new `out_data`.
- `out_data` holds its value while `out_valid`=1 and `out_ready`=0.
- Mid-operation reset:
  - Every output returns to its reset value asynchronously, and the captured word is discarded.
  - If `req_in` is still high after reset, the sender sees `ack_out`=0. The sink treats `req_in` as a fresh request and captures `data_in` again. Upstream owns de-duplication across reset.
- A `req_in` glitch shorter than one clock period may be missed. That is legal: the 4-phase sender never retracts `req_in` before `ack_out` rises.

## Timing
- Capture latency: `req_in` rises with setup met before edge k. `req_s` is high after edge k+SYNC_STAGES-1. `out_valid`, `ack_out` and `out_data` update at edge k+SYNC_STAGES (given `can_load`). With defaults that is 2 edges.
- Release latency: `req_in` falls before edge m. `ack_out` falls at edge m+SYNC_STAGES.
- Minimum handshake period is 2·SYNC_STAGES+2 clock cycles per word, plus the sender's return-to-zero delay. Peak throughput with defaults is one word per 6 cycles.
- `out_valid` assertion is never delayed by `out_ready`. A word can be consumed on the edge after it appears.
- `ack_out` never changes in the same edge as an `req_s` transition it has not yet observed. It is a pure function of the FSM state register.

## Structure
- Shared package `async_pkg` contains:
  - `typedef enum logic {IDLE, ACKED} bd4_state_t`
  - constant `BD4_SYNC_MIN = 2`
- Sub-module `sync_ff #(STAGES)` is a 1-bit flop chain with async active-low reset to 0, reusable across the async library.
- Top level holds the FSM, the WIDTH-bit data register and the valid flag; no other sub-modules.

## Test plan
- Single word:
  - Stimulus: `data_in`=8'hA5, `req_in`↑, `out_ready`=1.
  - Response: `out_valid`/`ack_out` rise 2 edges later with `out_data`=8'hA5. After `req_in`↓, `ack_out`↓ 2 edges later.
- Backpressure:
  - Stimulus: hold `out_ready`=0; send 8'h11, then raise `req_in` with 8'h22.
  - Response: `ack_out` stays 0 for 8'h22 and `out_data` stays 8'h11. Raise `out_ready` for one cycle: 8'h22 loads on that same edge and `out_valid` stays 1.
- Back-to-back stream:
  - Stimulus: 16 words 0..15 with the fastest legal sender and `out_ready`=1.
  - Response: all 16 received in order, none dropped or duplicated, spacing ≥6 cycles.
- Random ready: 200 random words with `out_ready` toggled randomly -> scoreboard match, and `out_data` stable whenever `out_valid && !out_ready`.
- Reset mid-handshake:
  - Stimulus: assert `rst_n`=0 while in ACKED with `req_in`=1.
  - Response: outputs go to 0 immediately without waiting for `clk`. After release with `req_in` still 1, the word is recaptured 2 edges later.
- SYNC_STAGES=3 build: repeat the single-word case -> capture latency is 3 edges.
